// File: rtl/duck_sprite_engine.sv
// Single-duck sprite engine: owns position, bounce flight, shot hit test,
// freeze/fall/respawn sequence and the registered per-pixel draw output
// that feeds one duck slot of the draw-priority mux.
module duck_sprite_engine #(
  parameter int unsigned X_START        = 0,
  parameter int unsigned Y_START        = 200,
  parameter int unsigned DUCK_W         = 16,
  parameter int unsigned DUCK_H         = 16,
  parameter int unsigned H_MAX          = 640,
  parameter int unsigned SKY_BOTTOM     = 360,
  parameter int unsigned SPEED          = 2,
  parameter int unsigned FALL_SPEED     = 4,
  parameter int unsigned HIT_FRAMES     = 30,
  parameter int unsigned RESPAWN_FRAMES = 60,
  parameter logic [5:0]  BODY_COLOR     = 6'b100100,
  parameter logic [5:0]  HEAD_COLOR     = 6'b001000,
  parameter logic [5:0]  HIT_COLOR      = 6'b110000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       frame_tick_i,
  input  logic       video_on_i,
  input  logic [9:0] pixel_x_i,
  input  logic [9:0] pixel_y_i,
  input  logic       shot_valid_i,
  input  logic [9:0] shot_x_i,
  input  logic [9:0] shot_y_i,
  output logic       duck_draw_o,
  output logic [5:0] duck_data_o,
  output logic       hit_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    StFly     = 2'd0,
    StHit     = 2'd1,
    StFall    = 2'd2,
    StRespawn = 2'd3
  } state_e;

  // All bound arithmetic is done in 11 bits so sums never wrap.
  localparam logic [10:0] XMax      = 11'(H_MAX - DUCK_W);
  localparam logic [10:0] YMax      = 11'(SKY_BOTTOM - DUCK_H);
  localparam logic [10:0] Speed     = 11'(SPEED);
  localparam logic [10:0] FallSpeed = 11'(FALL_SPEED);
  localparam logic [10:0] DuckW     = 11'(DUCK_W);
  localparam logic [10:0] DuckH     = 11'(DUCK_H);
  localparam logic [10:0] HeadX     = 11'(DUCK_W - 4);
  localparam logic [10:0] HeadY     = 11'd4;
  localparam logic [9:0]  XStart    = 10'(X_START);
  localparam logic [9:0]  YStart    = 10'(Y_START);
  localparam logic [6:0]  HitLast   = 7'(HIT_FRAMES - 1);
  localparam logic [6:0]  RespLast  = 7'(RESPAWN_FRAMES - 1);

  state_e     state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       dx_q, dx_d, dy_q, dy_d;
  logic [6:0] cnt_q, cnt_d;
  logic       hit_q, hit_d;
  logic       draw_q, draw_d;
  logic [5:0] data_q, data_d;

  logic [10:0] x_ext, y_ext, sx_ext, sy_ext, px_ext, py_ext;
  logic [9:0]  x_fly, y_fly;
  logic        dx_fly, dy_fly;
  logic        shot_in, pix_in, head_in;

  assign x_ext  = {1'b0, x_q};
  assign y_ext  = {1'b0, y_q};
  assign sx_ext = {1'b0, shot_x_i};
  assign sy_ext = {1'b0, shot_y_i};
  assign px_ext = {1'b0, pixel_x_i};
  assign py_ext = {1'b0, pixel_y_i};

  // Box membership for the shot aim point and the current pixel.
  always_comb begin
    shot_in = (sx_ext >= x_ext) && (sx_ext < x_ext + DuckW) &&
              (sy_ext >= y_ext) && (sy_ext < y_ext + DuckH);
    pix_in  = (px_ext >= x_ext) && (px_ext < x_ext + DuckW) &&
              (py_ext >= y_ext) && (py_ext < y_ext + DuckH);
    // Only meaningful when pix_in holds, so the subtractions cannot underflow.
    head_in = ((px_ext - x_ext) >= HeadX) && ((py_ext - y_ext) < HeadY);
  end

  // Candidate flight step on each axis, clamping and reversing at the limits.
  always_comb begin
    x_fly  = x_q;
    dx_fly = dx_q;
    if (dx_q) begin
      if (x_ext + Speed > XMax) begin
        x_fly  = XMax[9:0];
        dx_fly = 1'b0;
      end else begin
        x_fly = x_q + Speed[9:0];
      end
    end else begin
      if (x_ext < Speed) begin
        x_fly  = 10'd0;
        dx_fly = 1'b1;
      end else begin
        x_fly = x_q - Speed[9:0];
      end
    end

    y_fly  = y_q;
    dy_fly = dy_q;
    if (dy_q) begin
      if (y_ext + Speed > YMax) begin
        y_fly  = YMax[9:0];
        dy_fly = 1'b0;
      end else begin
        y_fly = y_q + Speed[9:0];
      end
    end else begin
      if (y_ext < Speed) begin
        y_fly  = 10'd0;
        dy_fly = 1'b1;
      end else begin
        y_fly = y_q - Speed[9:0];
      end
    end
  end

  // Next-state logic for the fly/hit/fall/respawn sequence.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    unique case (state_q)
      StFly: begin
        // A hit wins over a coincident tick: position stays where it was shot.
        if (shot_valid_i && shot_in) begin
          state_d = StHit;
          hit_d   = 1'b1;
          cnt_d   = 7'd0;
        end else if (frame_tick_i) begin
          x_d  = x_fly;
          y_d  = y_fly;
          dx_d = dx_fly;
          dy_d = dy_fly;
        end
      end
      StHit: begin
        if (frame_tick_i) begin
          if (cnt_q == HitLast) begin
            state_d = StFall;
            cnt_d   = 7'd0;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      StFall: begin
        if (frame_tick_i) begin
          if (y_ext + FallSpeed >= YMax) begin
            y_d     = YMax[9:0];
            state_d = StRespawn;
            cnt_d   = 7'd0;
          end else begin
            y_d = y_q + FallSpeed[9:0];
          end
        end
      end
      StRespawn: begin
        if (frame_tick_i) begin
          if (cnt_q == RespLast) begin
            state_d = StFly;
            x_d     = XStart;
            y_d     = YStart;
            dx_d    = 1'b1;
            dy_d    = 1'b0;
            cnt_d   = 7'd0;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      default: state_d = StFly;
    endcase
  end

  // Per-pixel colour selection; registered to give a fixed one-cycle lag.
  always_comb begin
    draw_d = 1'b0;
    data_d = 6'd0;
    if (video_on_i && (state_q != StRespawn) && pix_in) begin
      draw_d = 1'b1;
      if ((state_q == StHit) || (state_q == StFall)) begin
        data_d = HIT_COLOR;
      end else if (head_in) begin
        data_d = HEAD_COLOR;
      end else begin
        data_d = BODY_COLOR;
      end
    end
  end

  // State register; reset clears everything asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StFly;
      x_q     <= XStart;
      y_q     <= YStart;
      dx_q    <= 1'b1;
      dy_q    <= 1'b0;
      cnt_q   <= 7'd0;
      hit_q   <= 1'b0;
      draw_q  <= 1'b0;
      data_q  <= 6'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      draw_q  <= draw_d;
      data_q  <= data_d;
    end
  end

  assign duck_draw_o = draw_q;
  assign duck_data_o = data_q;
  assign hit_o       = hit_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_duck_sprite_engine.sv
// Scoreboard bench for duck_sprite_engine: stimulus pushes expected draw
// results and hit pulses; monitors pop and compare as outputs appear.
module tb_duck_sprite_engine;

  localparam logic [5:0] Body = 6'b100100;
  localparam logic [5:0] Head = 6'b001000;
  localparam logic [5:0] HitC = 6'b110000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       video_on = 1'b0;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic       shot_valid = 1'b0;
  logic [9:0] shot_x = '0;
  logic [9:0] shot_y = '0;
  logic       duck_draw;
  logic [5:0] duck_data;
  logic       hit;
  logic [1:0] state;

  always #5 clk = ~clk;

  duck_sprite_engine dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .frame_tick_i (frame_tick),
    .video_on_i   (video_on),
    .pixel_x_i    (pixel_x),
    .pixel_y_i    (pixel_y),
    .shot_valid_i (shot_valid),
    .shot_x_i     (shot_x),
    .shot_y_i     (shot_y),
    .duck_draw_o  (duck_draw),
    .duck_data_o  (duck_data),
    .hit_o        (hit),
    .state_o      (state)
  );

  typedef struct {
    string      name;
    logic       draw;
    logic [5:0] data;
  } exp_t;

  exp_t  draw_exp[$];
  string hit_exp[$];
  exp_t  e;
  int    total = 0;
  int    bad = 0;
  int    hits_seen = 0;
  logic  probe = 1'b0;
  logic  probe_pend = 1'b0;

  // Marks the cycle whose registered output answers a probe.
  always @(posedge clk) probe_pend <= probe;

  // Monitor: compare draw outputs on probe cycles and every hit pulse.
  always @(negedge clk) begin
    if (probe_pend) begin
      total++;
      if (draw_exp.size() == 0) begin
        bad++;
        $display("FAIL probe_unexpected: draw=%0b data=%b with empty queue", duck_draw, duck_data);
      end else begin
        e = draw_exp.pop_front();
        if (duck_draw !== e.draw || duck_data !== e.data) begin
          bad++;
          $display("FAIL %s: got draw=%0b data=%b, want draw=%0b data=%b",
                   e.name, duck_draw, duck_data, e.draw, e.data);
        end
      end
    end
    if (hit === 1'b1) begin
      hits_seen++;
      total++;
      if (hit_exp.size() == 0) begin
        bad++;
        $display("FAIL unexpected_hit: got hit=1, want hit=0");
      end else begin
        void'(hit_exp.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
    end
  endtask

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, expv);
    end
  endtask

  task automatic probe_px(input string name, input int px, input int py, input logic vo,
                          input logic ed, input logic [5:0] edat);
    exp_t t;
    t.name = name;
    t.draw = ed;
    t.data = edat;
    pixel_x  = 10'(px);
    pixel_y  = 10'(py);
    video_on = vo;
    probe    = 1'b1;
    draw_exp.push_back(t);
    cyc();
    video_on = 1'b0;
    probe    = 1'b0;
  endtask

  // Probes corners and just-outside pixels of a box at (bx,by).
  task automatic box(input string name, input int bx, input int by, input logic hitc);
    logic [5:0] cb, ch;
    cb = hitc ? HitC : Body;
    ch = hitc ? HitC : Head;
    probe_px({name, "_tl"}, bx, by, 1'b1, 1'b1, cb);
    probe_px({name, "_head"}, bx + 12, by, 1'b1, 1'b1, ch);
    probe_px({name, "_br"}, bx + 15, by + 15, 1'b1, 1'b1, cb);
    probe_px({name, "_right"}, bx + 16, by, 1'b1, 1'b0, 6'd0);
    probe_px({name, "_below"}, bx, by + 16, 1'b1, 1'b0, 6'd0);
    if (bx > 0) probe_px({name, "_left"}, bx - 1, by, 1'b1, 1'b0, 6'd0);
    if (by > 0) probe_px({name, "_above"}, bx, by - 1, 1'b1, 1'b0, 6'd0);
  endtask

  task automatic shoot(input string name, input int sx, input int sy, input logic with_tick,
                       input logic expect_hit);
    shot_x     = 10'(sx);
    shot_y     = 10'(sy);
    shot_valid = 1'b1;
    frame_tick = with_tick;
    if (expect_hit) hit_exp.push_back(name);
    cyc();
    shot_valid = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    chk("rst_state", int'(state), 0);
    chk("rst_draw", int'(duck_draw), 0);
    chk("rst_hit", int'(hit), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // Drawing at the reset position
    probe_px("p0_200", 0, 200, 1'b1, 1'b1, Body);
    probe_px("p12_200", 12, 200, 1'b1, 1'b1, Head);
    probe_px("p16_200", 16, 200, 1'b1, 1'b0, 6'd0);
    probe_px("p15_203", 15, 203, 1'b1, 1'b1, Head);
    probe_px("p15_215", 15, 215, 1'b1, 1'b1, Body);
    probe_px("p11_200", 11, 200, 1'b1, 1'b1, Body);
    probe_px("p12_204", 12, 204, 1'b1, 1'b1, Body);
    probe_px("p0_216", 0, 216, 1'b1, 1'b0, 6'd0);
    probe_px("blank", 0, 200, 1'b0, 1'b0, 6'd0);

    // Shot just right of the box misses
    shoot("miss", 16, 200, 1'b0, 1'b0);
    cyc();
    cyc();
    chk("miss_state", int'(state), 0);
    chk("miss_nohit", hits_seen, 0);

    // Flight and the top bounce
    ticks(10);
    chk("t10_state", int'(state), 0);
    box("t10", 20, 180, 1'b0);
    ticks(90);
    box("t100", 200, 0, 1'b0);
    ticks(1);
    box("t101", 202, 0, 1'b0);
    ticks(1);
    box("t102", 204, 2, 1'b0);

    // Right-edge bounce: x reaches 624 at tick 312
    ticks(210);
    box("t312", 624, 268, 1'b0);
    ticks(1);
    box("t313", 624, 266, 1'b0);
    ticks(1);
    box("t314", 622, 264, 1'b0);

    // Hit, freeze, fall, respawn
    do_reset();
    shoot("hit1", 5, 205, 1'b0, 1'b1);
    chk("hit1_state", int'(state), 1);
    cyc();
    cyc();
    chk("hit1_count", hits_seen, 1);
    box("hit", 0, 200, 1'b1);
    shoot("rehit", 3, 203, 1'b0, 1'b0);
    cyc();
    cyc();
    chk("rehit_nohit", hits_seen, 1);
    chk("rehit_state", int'(state), 1);
    ticks(29);
    chk("hit29_state", int'(state), 1);
    ticks(1);
    chk("fall_state", int'(state), 2);
    box("fall0", 0, 200, 1'b1);
    ticks(35);
    chk("fall35_state", int'(state), 2);
    box("fall35", 0, 340, 1'b1);
    ticks(1);
    chk("resp_state", int'(state), 3);
    chk("resp_y", int'(dut.y_q), 344);
    probe_px("resp_p0_344", 0, 344, 1'b1, 1'b0, 6'd0);
    probe_px("resp_p8_350", 8, 350, 1'b1, 1'b0, 6'd0);
    shoot("resp_shot", 5, 350, 1'b0, 1'b0);
    cyc();
    chk("resp_nohit", hits_seen, 1);
    ticks(59);
    chk("resp59_state", int'(state), 3);
    ticks(1);
    chk("fly_again_state", int'(state), 0);
    box("respawned", 0, 200, 1'b0);

    // Shot coincident with a tick: hit on the old box, no advance
    shoot("coinc", 1, 201, 1'b1, 1'b1);
    chk("coinc_state", int'(state), 1);
    cyc();
    cyc();
    chk("coinc_count", hits_seen, 2);
    chk("coinc_x", int'(dut.x_q), 0);
    box("coinc", 0, 200, 1'b1);

    // Asynchronous reset in the middle of a fall
    ticks(30);
    chk("fall2_state", int'(state), 2);
    ticks(3);
    pixel_x  = 10'd0;
    pixel_y  = 10'd212;
    video_on = 1'b1;
    cyc();
    cyc();
    chk("prerst_draw", int'(duck_draw), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_draw", int'(duck_draw), 0);
    chk("arst_hit", int'(hit), 0);
    chk("arst_x", int'(dut.x_q), 0);
    chk("arst_y", int'(dut.y_q), 200);
    video_on = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    ticks(1);
    chk("postrst_state", int'(state), 0);
    box("postrst", 2, 198, 1'b0);

    cyc();
    cyc();
    total++;
    if (hit_exp.size() != 0 || draw_exp.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d hits and %0d probes pending, want 0 and 0",
               hit_exp.size(), draw_exp.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/duck_sprite_engine.md
# duck_sprite_engine

Upstream producer for the pixel draw-priority mux: owns one duck's position, motion, hit detection and fall/respawn sequence. It compares the incoming VGA pixel coordinate against the duck's bounding box and emits `duck_draw` / `duck_data[5:0]`. These outputs drive one of the mux's duck inputs. Four instances, with different start parameters, feed the four duck slots.

## Interface
Parameters:
- X_START, 0, reset/respawn x of the box's top-left corner
- Y_START, 200, reset/respawn y of the box's top-left corner
- DUCK_W, 16, box width in pixels
- DUCK_H, 16, box height in pixels
- H_MAX, 640, visible width
- SKY_BOTTOM, 360, first row below the sky region
- SPEED, 2, flight step per frame tick, applied on each axis
- FALL_SPEED, 4, fall step per frame tick
- HIT_FRAMES, 30, freeze duration in frame ticks
- RESPAWN_FRAMES, 60, invisible duration in frame ticks
- BODY_COLOR, 6'b100100, 6-bit colour in RRGGBB order
- HEAD_COLOR, 6'b001000
- HIT_COLOR, 6'b110000

Ports:
- clk  in  1  system clock (pixel clock domain)
- rst_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse, once per frame, in vertical blank
- video_on  in  1  current pixel is in the visible area
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel row
- shot_valid  in  1  one-cycle trigger pulse
- shot_x  in  10  aim column, sampled when shot_valid=1
- shot_y  in  10  aim row, sampled when shot_valid=1
- duck_draw  out  1  registered; this pixel belongs to the duck
- duck_data  out  6  registered pixel colour
- hit  out  1  one-cycle pulse when the duck is struck
- state  out  2  FLY=0, HIT=1, FALL=2, RESPAWN=3

## Operation
- Internal registers:
  - x, y: 10-bit unsigned top-left corner
  - dx: 1=right
  - dy: 1=down
  - frame counter: 7 bits, sufficient for both HIT_FRAMES and RESPAWN_FRAMES
- All bound compares are computed in 11 bits, so the sum never wraps.
- Reset values:
  - state=FLY, x=X_START, y=Y_START, dx=1 (right), dy=0 (up), counter=0
  - duck_draw=0, duck_data=0, hit=0
- FLY, on frame_tick, x axis:
  - dx=1 and x+SPEED > H_MAX-DUCK_W: x<=H_MAX-DUCK_W, dx<=0.
  - dx=0 and x < SPEED: x<=0, dx<=1.
  - Otherwise x steps by ±SPEED.
- FLY, on frame_tick, y axis (same rule, sky region only):
  - Upper bound is 0.
  - Lower bound is SKY_BOTTOM-DUCK_H.
- FLY, on shot_valid:
  - Hit test: x<=shot_x<x+DUCK_W and y<=shot_y<y+DUCK_H.
  - On a hit: state<=HIT, hit=1 for the next cycle only, counter<=0.
- HIT:
  - Position is frozen.
  - The counter increments per frame_tick.
  - When the counter reaches HIT_FRAMES-1 and a tick occurs: state<=FALL.
- FALL, on frame_tick:
  - y+FALL_SPEED >= SKY_BOTTOM-DUCK_H: y<=SKY_BOTTOM-DUCK_H, state<=RESPAWN, counter<=0.
  - Otherwise y<=y+FALL_SPEED.
- RESPAWN:
  - The duck is not drawn.
  - After RESPAWN_FRAMES ticks: state<=FLY, x=X_START, y=Y_START, dx=1, dy=0.
- Drawing: inside = video_on && state!=RESPAWN && pixel within the box.
  - If inside: duck_draw<=1.
    - state HIT or FALL: duck_data<=HIT_COLOR.
    - Else, head region (pixel_x-x >= DUCK_W-4 and pixel_y-y < 4): duck_data<=HEAD_COLOR.
    - Else: duck_data<=BODY_COLOR.
  - If not inside: duck_draw<=0, duck_data<=0.
- Simultaneous shot_valid and frame_tick in FLY:
  - The hit test uses the pre-update position.
  - A hit takes priority: the position does not advance on that tick.
- shot_valid in HIT, FALL or RESPAWN is ignored: no hit pulse.

## Timing
- duck_draw/duck_data lag pixel_x/pixel_y/video_on by exactly 1 cycle. The downstream mux registers again, so the total is 2 cycles from coordinate to colour.
- hit is asserted the cycle after shot_valid and lasts 1 cycle.
- state updates the cycle after the causing frame_tick or shot_valid.
- A position update becomes visible to the draw compare on the cycle after frame_tick. It is stable for the whole visible frame because the tick occurs in blank.
- Reset mid-operation, in any state: all registers return to reset values immediately (asynchronously). duck_draw=0 while rst_n=0.

## Test plan
- Reset release, video_on=1, pixel (0,200) → next cycle duck_draw=1, duck_data=BODY_COLOR.
  - Pixel (12,200) → HEAD_COLOR.
  - Pixel (16,200) → duck_draw=0, duck_data=0.
- 10 frame_ticks after reset → x=20, y=180, state=0. Then 90 more ticks → y=0.
  - Next tick: y=0, dy=1.
  - Following tick: y=2.
- Force x=624, dx=1, then one tick → x=624, dx=0. Next tick → x=622.
- After reset, shot (5,205) with shot_valid → hit=1 for exactly one cycle, state=1, draw colour HIT_COLOR.
  - After 30 ticks: state=2.
  - After 36 more ticks: y=344, state=3, duck_draw=0 everywhere.
  - After 60 ticks: state=0 at (0,200).
- Miss and ignore cases:
  - Shot (16,200) in FLY → no hit, state stays 0.
  - Second shot inside the box during HIT → no hit pulse.
  - Shot coincident with frame_tick inside the old box → HIT, x unchanged.
- Assert rst_n=0 during FALL → same cycle state=0, x=0, y=200, duck_draw=0, hit=0. Release → normal flight resumes.
